// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl: sequences one ring-oscillator measurement run.
// A run enables the ring and waits WARMUP_CYCLES for it to settle. It then
// counts synchronized rising edges of the divided ring output over a window
// of GATE_CYCLES system clocks, and latches the result.
// Optional feature macro: MEAS_MINMAX_EN adds running min/max result ports.
module ring_osc_meas_ctrl #(
  parameter int GATE_CYCLES   = 50_000_000,
  parameter int WARMUP_CYCLES = 1024,
  parameter int CNT_W         = 25,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_div_i,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             led
`ifdef MEAS_MINMAX_EN
  ,
  output logic [CNT_W-1:0] cnt_min,
  output logic [CNT_W-1:0] cnt_max
`endif
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [WW-1:0]          warm_q, warm_d;
  logic [CNT_W-1:0]       edge_q, edge_d;
  logic                   ovf_int_q, ovf_int_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;
  logic                   led_q;
  logic                   rise;
  logic                   finish;

  // Synchronize the asynchronous ring output, plus one flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], osc_div_i};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise   = sync_q[SYNC_STAGES-1] & ~sync_d_q;
  // Last cycle of the window; results are captured on this edge so they
  // become visible together with the done pulse.
  assign finish = (state_q == S_MEASURE) && (gate_q == GATE_LAST);

  // Next-state logic: FSM sequencing, window timers and saturating edge count
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    warm_d    = warm_q;
    edge_d    = edge_q;
    ovf_int_d = ovf_int_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WARMUP;
          gate_d    = '0;
          warm_d    = '0;
          edge_d    = '0;
          ovf_int_d = 1'b0;
        end
      end
      S_WARMUP: begin
        // Rises are ignored here, but the sync chain keeps running so the
        // first MEASURE cycle does not see a stale edge.
        if (warm_q == WARM_LAST) state_d = S_MEASURE;
        else                     warm_d  = warm_q + 1'b1;
      end
      S_MEASURE: begin
        if (rise) begin
          if (edge_q == CNT_MAX) ovf_int_d = 1'b1;
          else                   edge_d    = edge_q + 1'b1;
        end
        if (gate_q == GATE_LAST) state_d = S_DONE;
        else                     gate_d  = gate_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gate_q    <= '0;
      warm_q    <= '0;
      edge_q    <= '0;
      ovf_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      warm_q    <= warm_d;
      edge_q    <= edge_d;
      ovf_int_q <= ovf_int_d;
    end
  end

  // Result latch: held until the next completed run, never cleared by start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      led_q      <= 1'b0;
    end else if (finish) begin
      count_q    <= edge_d;
      overflow_q <= ovf_int_d;
      led_q      <= ~led_q;
    end
  end

`ifdef MEAS_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;

  // Running extremes; the reset values make the first run load both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (finish) begin
      if (edge_d < min_q) min_q <= edge_d;
      if (edge_d > max_q) max_q <= edge_d;
    end
  end

  assign cnt_min = min_q;
  assign cnt_max = max_q;
`endif

  assign osc_en   = (state_q == S_WARMUP) || (state_q == S_MEASURE);
  assign busy     = osc_en;
  assign done     = (state_q == S_DONE);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign led      = led_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Directed bench for ring_osc_meas_ctrl (GATE=100, WARMUP=8, SYNC=2).
// Main instance uses CNT_W=8; a second CNT_W=4 instance shares the inputs
// and is used to observe saturation.
module tb_ring_osc_meas_ctrl;
  localparam int G = 100;
  localparam int W = 8;
  localparam int LIMIT = 400;

  logic clk, rst, start, osc;
  logic osc_en, busy, done, overflow, led;
  logic [7:0] count;
  logic osc_en4, busy4, done4, overflow4, led4;
  logic [3:0] count4;
`ifdef MEAS_MINMAX_EN
  logic [7:0] cnt_min, cnt_max;
  logic [3:0] cnt_min4, cnt_max4;
`endif

  int tests = 0;
  int fails = 0;
  int osc_hi_ns = 50;
  int osc_lo_ns = 50;
  bit osc_static = 0;

  ring_osc_meas_ctrl #(.GATE_CYCLES(G), .WARMUP_CYCLES(W), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .osc_div_i(osc),
    .osc_en(osc_en), .busy(busy), .done(done), .count(count),
    .overflow(overflow), .led(led)
`ifdef MEAS_MINMAX_EN
    , .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
  );

  ring_osc_meas_ctrl #(.GATE_CYCLES(G), .WARMUP_CYCLES(W), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .osc_div_i(osc),
    .osc_en(osc_en4), .busy(busy4), .done(done4), .count(count4),
    .overflow(overflow4), .led(led4)
`ifdef MEAS_MINMAX_EN
    , .cnt_min(cnt_min4), .cnt_max(cnt_max4)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Free-running ring model; transitions sit 3 ns off the 10 ns grid,
  // away from the clock edges at 5 ns + n*10 ns.
  initial begin
    osc = 0;
    #3;
    forever begin
      if (osc_static) begin
        osc = 0;
        #10;
      end else begin
        osc = 1;
        #(osc_hi_ns);
        osc = 0;
        #(osc_lo_ns);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    start = 0;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    start = 0;
    repeat (3) tick();
    tests++; if (osc_en !== 1'b0) begin fails++; $display("FAIL reset_osc_en got=%b exp=0", osc_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests++; if (overflow !== 1'b0 || led !== 1'b0) begin fails++; $display("FAIL reset_ovf_led got=%b%b exp=00", overflow, led); end
`ifdef MEAS_MINMAX_EN
    tests++; if (cnt_min !== 8'hFF || cnt_max !== 8'h00) begin fails++; $display("FAIL reset_minmax got=%0d/%0d exp=255/0", cnt_min, cnt_max); end
`endif
    rst = 0;
    repeat (2) tick();
  endtask

  // Period 10 clk: busy after edges 1..108, done only after edge 109
  // (cycle 110 counting the start cycle as cycle 1).
  task automatic test_basic();
    int busy_cnt = 0, done_cnt = 0, first_done = -1;
    osc_static = 0; osc_hi_ns = 50; osc_lo_ns = 50;
    repeat (20) tick();
    tick();
    start = 1;
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (n == 1) start = 0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = n;
          tests++; if (count !== 8'd10) begin fails++; $display("FAIL basic_count got=%0d exp=10", count); end
          tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
          tests++; if (led !== 1'b1) begin fails++; $display("FAIL basic_led got=%b exp=1", led); end
          tests++; if (osc_en !== 1'b0) begin fails++; $display("FAIL basic_osc_en_done got=%b exp=0", osc_en); end
        end
      end
    end
    tests++; if (busy_cnt != W + G) begin fails++; $display("FAIL basic_busy_len got=%0d exp=%0d", busy_cnt, W + G); end
    tests++; if (first_done != W + G + 1) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", first_done, W + G + 1); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_saturation();
    int cyc;
    osc_hi_ns = 20; osc_lo_ns = 20;   // period 4 clk -> 25 rises
    repeat (30) tick();
    pulse_start();
    wait_done(cyc);
    tests++; if (!done) begin fails++; $display("FAIL sat_timeout got=%0d cycles exp=done", cyc); end
    tests++; if (count4 !== 4'd15 || overflow4 !== 1'b1) begin fails++; $display("FAIL sat_w4 got=%0d/%b exp=15/1", count4, overflow4); end
    tests++; if (count !== 8'd25 || overflow !== 1'b0) begin fails++; $display("FAIL sat_w8 got=%0d/%b exp=25/0", count, overflow); end
    osc_hi_ns = 100; osc_lo_ns = 100; // period 20 clk -> 5 rises
    repeat (40) tick();
    pulse_start();
    wait_done(cyc);
    tests++; if (count4 !== 4'd5 || overflow4 !== 1'b0) begin fails++; $display("FAIL sat_rerun_w4 got=%0d/%b exp=5/0", count4, overflow4); end
    tests++; if (count !== 8'd5) begin fails++; $display("FAIL sat_rerun_w8 got=%0d exp=5", count); end
  endtask

  task automatic test_ignored_start();
    int done_cnt = 0;
    osc_hi_ns = 50; osc_lo_ns = 50;
    repeat (40) tick();
    tick();
    start = 1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      start = (n == 50) ? 1'b1 : 1'b0;
      if (done) done_cnt++;
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL ignored_done_cnt got=%0d exp=1", done_cnt); end
    tests++; if (count !== 8'd10) begin fails++; $display("FAIL ignored_count got=%0d exp=10", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignored_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    tick();
    start = 1;
    tick();            // edge 1 samples start
    start = 0;
    repeat (48) tick(); // after edge 49: MEASURE with gate=40
    tests++; if (busy !== 1'b1 || osc_en !== 1'b1) begin fails++; $display("FAIL midrst_pre got=%b%b exp=11", busy, osc_en); end
    #2 rst = 1;
    #1;
    tests++; if (osc_en !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_ctrl got=%b%b exp=00", osc_en, busy); end
    tests++; if (count !== 8'd0 || led !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL midrst_result got=%0d/%b/%b exp=0/0/0", count, led, overflow); end
    tick();
    rst = 0;
    repeat (2) tick();
    pulse_start();
    wait_done(cyc);
    tests++; if (!done || count !== 8'd10 || led !== 1'b1) begin fails++; $display("FAIL midrst_rerun got=%b/%0d/%b exp=1/10/1", done, count, led); end
  endtask

  // Held start with a static ring: runs repeat every W+G+2 = 110 clks.
  task automatic test_back_to_back();
    int dn[3];
    logic ld[3];
    int k = 0;
    osc_static = 1;
    do_reset();
    start = 1;
    for (int n = 1; n <= 340; n++) begin
      tick();
      if (done && k < 3) begin
        dn[k] = n;
        ld[k] = led;
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL b2b_count%0d got=%0d exp=0", k, count); end
        k++;
      end
    end
    start = 0;
    tests++; if (k != 3) begin fails++; $display("FAIL b2b_done_cnt got=%0d exp=3", k); end
    if (k == 3) begin
      tests++; if (dn[1] - dn[0] != 110 || dn[2] - dn[1] != 110) begin fails++; $display("FAIL b2b_period got=%0d/%0d exp=110/110", dn[1] - dn[0], dn[2] - dn[1]); end
      tests++; if (ld[0] !== 1'b1 || ld[1] !== 1'b0 || ld[2] !== 1'b1) begin fails++; $display("FAIL b2b_led got=%b%b%b exp=101", ld[0], ld[1], ld[2]); end
    end
    osc_static = 0;
  endtask

`ifdef MEAS_MINMAX_EN
  task automatic test_minmax();
    int cyc;
    int hi[3] = '{50, 30, 100};
    int lo[3] = '{50, 20, 100};
    logic [7:0] exp_c[3] = '{8'd10, 8'd20, 8'd5};
    do_reset();
    for (int r = 0; r < 3; r++) begin
      osc_hi_ns = hi[r]; osc_lo_ns = lo[r];
      repeat (40) tick();
      pulse_start();
      wait_done(cyc);
      tests++; if (count !== exp_c[r]) begin fails++; $display("FAIL minmax_count%0d got=%0d exp=%0d", r, count, exp_c[r]); end
      if (r == 0) begin
        tests++; if (cnt_min !== 8'd10 || cnt_max !== 8'd10) begin fails++; $display("FAIL minmax_first got=%0d/%0d exp=10/10", cnt_min, cnt_max); end
      end
    end
    tests++; if (cnt_min !== 8'd5 || cnt_max !== 8'd20) begin fails++; $display("FAIL minmax_final got=%0d/%0d exp=5/20", cnt_min, cnt_max); end
  endtask
`endif

  initial begin
    rst = 1;
    start = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
`ifdef MEAS_MINMAX_EN
    test_minmax();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
